hsv_core_alu_shift_commit: RTL

Back half of the ALU pipeline; consumes everything the ALU bitwise/operand setup stage emits.
- Performs a 64→32 funnel shift and a 33-bit add on the prepared operands.
- Selects the final result (adder, set-less-than, or shift/bitwise) and presents it to commit over a valid/ready handshake.
- Generates the stall that the setup stage obeys, closing the loop on the same interface from the receiving end.

---
 rtl/hsv_core_pkg.sv | 36 +++
 rtl/hsv_core_alu_skid_fifo.sv | 68 ++++++
 rtl/hsv_core_alu_shift_commit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/hsv_core_pkg.sv
// Shared ALU pipeline types: operand widths, result-select encoding and op metadata.
package hsv_core_pkg;

  typedef logic [31:0] word;
  typedef logic [4:0]  shift;
  typedef logic [32:0] adder_in;

  typedef enum logic [1:0] {
    ALU_RESULT_ADDER,
    ALU_RESULT_SLT,
    ALU_RESULT_SHIFT
  } alu_result_sel_t;

  typedef struct packed {
    alu_result_sel_t result_select;
    logic [4:0]      rd;
    logic [3:0]      tag;
  } alu_data_t;

  typedef struct packed {
    alu_data_t data;
    word       result;
  } alu_commit_t;

  // The shift path also carries bitwise results prepared upstream.
  function automatic word alu_select(alu_result_sel_t sel, adder_in sum, word shift_res);
    word r;
    case (sel)
      ALU_RESULT_ADDER: r = sum[31:0];
      ALU_RESULT_SLT:   r = {31'b0, sum[32]};
      default:          r = shift_res;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hsv_core_alu_skid_fifo.sv
// Parametric-depth valid/ready skid FIFO with fall-through when empty; reports next occupancy.
module hsv_core_alu_skid_fifo
  import hsv_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    level_next
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             empty, rd, wr;

  assign empty     = (count == '0);
  assign out_valid = ~empty | in_valid;
  assign out_data  = empty ? in_data : mem[rd_ptr];
  assign rd        = ~empty & out_ready;
  // An entry arriving at an empty FIFO bypasses storage if it is taken this cycle.
  assign wr        = in_valid & ~(empty & out_ready);

  always_comb begin
    level_next = count;
    if (flush)
      level_next = '0;
    else
      level_next = count + CW'(wr) - CW'(rd);
  end

  function automatic logic [AW-1:0] bump(logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= level_next;
      if (rd) rd_ptr <= bump(rd_ptr);
      if (wr) wr_ptr <= bump(wr_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !flush) mem[wr_ptr] <= in_data;
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(!flush && wr && count == CW'(DEPTH)));

endmodule

// File: rtl/hsv_core_alu_shift_commit.sv
// ALU back half: funnel shift + 33-bit add, result select, commit handshake and stall.
// Optional output skid FIFO with registered stall under HSV_ALU_SKID_BUFFER_EN.
module hsv_core_alu_shift_commit
  import hsv_core_pkg::*;
#(
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic      clk_core,
  input  logic      rst_core_n,
  input  logic      flush_req,
  input  logic      valid_i,
  input  alu_data_t in_alu_data,
  input  word       in_shift_lo,
  input  word       in_shift_hi,
  input  shift      in_shift_count,
  input  adder_in   in_adder_a,
  input  adder_in   in_adder_b,
  output logic      stall_o,
  output logic      valid_o,
  input  logic      ready_i,
  output alu_data_t out_alu_data,
  output word       out_result
);

  if (SKID_DEPTH < 4) begin : g_depth_check
    $error("SKID_DEPTH must be at least 4");
  end

  logic      a_valid, a_nxt;
  word       a_shift;
  adder_in   a_sum;
  alu_data_t a_data;
  logic      b_valid, b_nxt;
  word       b_result;
  alu_data_t b_data;
  logic      hold;
  word       shift_res;
  adder_in   sum;

  assign shift_res = word'({in_shift_hi, in_shift_lo} >> in_shift_count);
  assign sum       = in_adder_a + in_adder_b;

  // An op held by the setup stage while stall_o is high must not be captured twice.
  always_comb begin
    a_nxt = a_valid;
    b_nxt = b_valid;
    if (flush_req) begin
      a_nxt = 1'b0;
      b_nxt = 1'b0;
    end else if (!hold) begin
      a_nxt = valid_i & ~stall_o;
      b_nxt = a_valid;
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
    end else begin
      a_valid <= a_nxt;
      b_valid <= b_nxt;
    end
  end

  always_ff @(posedge clk_core) begin
    if (!hold) begin
      a_shift  <= shift_res;
      a_sum    <= sum;
      a_data   <= in_alu_data;
      b_result <= alu_select(a_data.result_select, a_sum, a_shift);
      b_data   <= a_data;
    end
  end

`ifdef HSV_ALU_SKID_BUFFER_EN
  localparam int unsigned CW = $clog2(SKID_DEPTH + 1);

  logic          stall_q;
  logic [CW-1:0] level_next;
  alu_commit_t   fifo_in, fifo_out;
  int unsigned   occupancy_next;

  assign hold    = 1'b0;
  assign stall_o = stall_q;
  assign fifo_in = '{data: b_data, result: b_result};

  hsv_core_alu_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH ($bits(alu_commit_t))
  ) u_skid (
    .clk        (clk_core),
    .rst_n      (rst_core_n),
    .flush      (flush_req),
    .in_valid   (b_valid),
    .in_data    (fifo_in),
    .out_valid  (valid_o),
    .out_ready  (ready_i),
    .out_data   (fifo_out),
    .level_next (level_next)
  );

  assign out_result   = fifo_out.result;
  assign out_alu_data = fifo_out.data;

  // Asserting one slot early covers the cycle the setup stage needs to react.
  assign occupancy_next = 32'(level_next) + 32'(a_nxt) + 32'(b_nxt);

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n)
      stall_q <= 1'b0;
    else if (flush_req)
      stall_q <= 1'b0;
    else
      stall_q <= (occupancy_next >= SKID_DEPTH - 1);
  end
`else
  assign stall_o      = b_valid & ~ready_i;
  assign hold         = stall_o;
  assign valid_o      = b_valid;
  assign out_result   = b_result;
  assign out_alu_data = b_data;
`endif

endmodule
